// File: rtl/top_level_if.sv
// top_level_if: byte-wide data memory bus between the encoder FSM and dm1.
interface top_level_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       we;
  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/top_level.sv
// top_level: reads NUM_MSGS 11-bit messages from dm1, writes SECDED-extended Hamming(16,11) words back.
// Macro DM_ZERO_INIT_EN gives dm1.core an all-zero initial value; otherwise it starts uninitialised.
module top_level_dm (
  input logic clk,
  top_level_if.slave bus
);
`ifdef DM_ZERO_INIT_EN
  logic [7:0] core [0:255] = '{default: 8'h00};
`else
  logic [7:0] core [0:255];
`endif
  assign bus.rdata = core[bus.addr];
  always_ff @(posedge clk)
    if (bus.we) core[bus.addr] <= bus.wdata;
endmodule

module top_level #(
  parameter int NUM_MSGS = 15,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 30
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  typedef enum logic [2:0] {RD_HI, RD_LO, WR_HI, WR_LO, DONE} state_t;
  localparam logic [7:0] IB   = 8'(IN_BASE);
  localparam logic [7:0] OB   = 8'(OUT_BASE);
  localparam logic [7:0] LAST = 8'(NUM_MSGS - 1);
  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d, lo_q, lo_d, off;
  logic [2:0]  hi_q, hi_d;
  logic [11:1] d;
  logic        p8, p4, p2, p1, p0;
  logic [15:0] w;
  top_level_if bus ();
  top_level_dm dm1 (.clk(clk), .bus(bus));
  assign off  = {idx_q[6:0], 1'b0};
  assign d    = {hi_q, lo_q};
  assign p8   = ^d[11:5];
  assign p4   = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
  assign p2   = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1   = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0   = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
  assign w    = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  assign done = state_q == DONE;
  always_comb begin
    bus.addr  = (state_q == RD_HI) ? IB + off + 8'd1 :
                (state_q == RD_LO) ? IB + off :
                (state_q == WR_HI) ? OB + off + 8'd1 : OB + off;
    bus.wdata = (state_q == WR_HI) ? w[15:8] : w[7:0];
    bus.we    = !reset && (state_q == WR_HI || state_q == WR_LO);
    hi_d      = (state_q == RD_HI) ? bus.rdata[2:0] : hi_q;
    lo_d      = (state_q == RD_LO) ? bus.rdata : lo_q;
    idx_d     = (state_q == WR_LO && idx_q != LAST) ? idx_q + 8'd1 : idx_q;
    case (state_q)
      RD_HI:   state_d = RD_LO;
      RD_LO:   state_d = WR_HI;
      WR_HI:   state_d = WR_LO;
      WR_LO:   state_d = (idx_q == LAST) ? DONE : RD_HI;
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= RD_HI;
      idx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: scoreboard bench for top_level; expected words queued at preload, checked as each message completes.
module tb_top_level;
  localparam int N  = 15;
  localparam int IB = 0;
  localparam int OB = 30;
  typedef struct {int idx; logic [7:0] hi; logic [7:0] lo;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic [7:0] snap [0:255];
  top_level #(.NUM_MSGS(N), .IN_BASE(IB), .OUT_BASE(OB)) dut (.clk(clk), .reset(reset), .done(done));
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [7:0] b1, input logic [7:0] b0);
    logic [11:1] m;
    logic q8, q4, q2, q1, q0;
    m  = {b1[2:0], b0};
    q8 = m[11] ^ m[10] ^ m[9] ^ m[8] ^ m[7] ^ m[6] ^ m[5];
    q4 = m[11] ^ m[10] ^ m[9] ^ m[8] ^ m[4] ^ m[3] ^ m[2];
    q2 = m[11] ^ m[10] ^ m[7] ^ m[6] ^ m[4] ^ m[3] ^ m[1];
    q1 = m[11] ^ m[9] ^ m[7] ^ m[5] ^ m[4] ^ m[2] ^ m[1];
    q0 = (^m) ^ q8 ^ q4 ^ q2 ^ q1;
    return {m[11:5], q8, m[4:2], q4, m[1], q2, q1, q0};
  endfunction

  task automatic load(input int i, input logic [7:0] b1, input logic [7:0] b0,
                      input logic [7:0] eh, input logic [7:0] el);
    exp_t e;
    dut.dm1.core[IB + 2*i + 1] = b1;
    dut.dm1.core[IB + 2*i]     = b0;
    e.idx = i;
    e.hi  = eh;
    e.lo  = el;
    sb.push_back(e);
  endtask

  task automatic load_rand(input int i);
    logic [7:0] b1, b0;
    logic [15:0] w;
    b1 = 8'($urandom);
    b0 = 8'($urandom);
    w  = enc(b1, b0);
    load(i, b1, b0, w[15:8], w[7:0]);
  endtask

  task automatic take_snap();
    for (int k = 0; k < 256; k++) snap[k] = dut.dm1.core[k];
  endtask

  task automatic run_edges(input string name);
    exp_t e;
    for (int t = 1; t <= 4*N; t++) begin
      @(posedge clk);
      #1;
      if (t < 4*N) begin
        tests++;
        if (done !== 1'b0) begin
          fails++;
          $display("FAIL %s done_early edge %0d: got %b want 0", name, t, done);
        end
      end
      if (t % 4 == 0) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL %s scoreboard_empty edge %0d: got 0 entries want 1", name, t);
        end else begin
          e = sb.pop_front();
          if (e.idx != t/4 - 1 || dut.dm1.core[OB + 2*e.idx + 1] !== e.hi || dut.dm1.core[OB + 2*e.idx] !== e.lo) begin
            fails++;
            $display("FAIL %s msg%0d: got %h%h want %h%h", name, e.idx,
                     dut.dm1.core[OB + 2*e.idx + 1], dut.dm1.core[OB + 2*e.idx], e.hi, e.lo);
          end
        end
      end
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s done_final: got %b want 1", name, done);
    end
  endtask

  task automatic check_untouched(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++)
      if ((k < OB || k >= OB + 2*N) && dut.dm1.core[k] !== snap[k]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s untouched: got %0d changed bytes want 0", name, bad);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 256; k++) dut.dm1.core[k] = 8'($urandom);
    for (int k = 0; k < 256; k++) snap[k] = dut.dm1.core[k];
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    tests++;
    if (dut.state_q !== dut.RD_HI || dut.idx_q !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d/%0d want 0/0", dut.state_q, dut.idx_q);
    end
    check_untouched("reset");
    for (int k = OB; k < OB + 2*N; k++) begin
      tests++;
      if (dut.dm1.core[k] !== snap[k]) begin
        fails++;
        $display("FAIL reset_out_byte %0d: got %h want %h", k, dut.dm1.core[k], snap[k]);
      end
    end
  endtask

  task automatic test_directed();
    load(0, 8'h00, 8'h00, 8'h00, 8'h00);
    load(1, 8'h07, 8'hFF, 8'hFF, 8'hFF);
    load(2, 8'h04, 8'h00, 8'h81, 8'h17);
    load(3, 8'h00, 8'h01, 8'h00, 8'h0F);
    load(4, 8'hF8, 8'h00, 8'h00, 8'h00);
    for (int i = 5; i < N; i++) load_rand(i);
    take_snap();
    start_run();
    run_edges("directed");
    check_untouched("directed");
  endtask

  task automatic test_random_absorb();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_done: got %b want 0", done);
    end
    for (int i = 0; i < N; i++) load_rand(i);
    take_snap();
    @(negedge clk);
    reset = 1'b0;
    run_edges("random");
    check_untouched("random");
    for (int k = 0; k < 256; k++) snap[k] = dut.dm1.core[k];
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b1) begin
        fails++;
        $display("FAIL absorb_done cycle %0d: got %b want 1", t, done);
      end
    end
    for (int k = OB; k < OB + 2*N; k++) begin
      tests++;
      if (dut.dm1.core[k] !== snap[k]) begin
        fails++;
        $display("FAIL absorb_byte %0d: got %h want %h", k, dut.dm1.core[k], snap[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b1, b0;
    for (int i = 0; i < N; i++) begin
      b1 = 8'($urandom);
      b0 = 8'($urandom);
      dut.dm1.core[IB + 2*i + 1] = b1;
      dut.dm1.core[IB + 2*i]     = b0;
    end
    start_run();
    repeat (25) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) load_rand(i);
    take_snap();
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_done: got %b want 0", done);
    end
    check_untouched("mid_reset_hold");
    @(negedge clk);
    reset = 1'b0;
    run_edges("mid_reset");
    check_untouched("mid_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_absorb();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 Parameter NUM_MSGS, default 15: number of 11-bit messages encoded per run.
REQ-002 Parameter IN_BASE, default 0: byte address of message 0 in data memory.
REQ-003 Parameter OUT_BASE, default 30: byte address of encoded word 0 in data memory.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high; also serves as the start request.
REQ-006 done  output  1  high when all NUM_MSGS words have been written.
REQ-007 Data memory SHALL be instance dm1 containing array core[0:255] of 8-bit bytes, hierarchically accessible for preload and inspection.

Function
REQ-008 Message i (0..NUM_MSGS-1) SHALL be read as d[11:9]=core[IN_BASE+2i+1][2:0] and d[8:1]=core[IN_BASE+2i]; core[IN_BASE+2i+1][7:3] ignored.
REQ-009 Parity: p8=^d[11:5]; p4=d11^d10^d9^d8^d4^d3^d2; p2=d11^d10^d7^d6^d4^d3^d1; p1=d11^d9^d7^d5^d4^d2^d1; p0=^d[11:1]^p8^p4^p2^p1.
REQ-010 Encoded word W[15:0]={d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}.
REQ-011 W[15:8] SHALL be written to core[OUT_BASE+2i+1] and W[7:0] to core[OUT_BASE+2i].
REQ-012 dm1: asynchronous read, synchronous write, one access per cycle.
REQ-013 FSM states RD_HI, RD_LO, WR_HI, WR_LO, DONE; one cycle each.
REQ-014 Transitions: RD_HI->RD_LO->WR_HI->WR_LO; WR_LO->RD_HI with index+1 if index<NUM_MSGS-1, else ->DONE.
REQ-015 Latency: message i is complete after rising edge 4(i+1) counted from the first edge with reset low; done SHALL be high after edge 4*NUM_MSGS (edge 60 at default).
REQ-016 DONE is absorbing: done stays high and memory is untouched until the next reset.
REQ-017 No byte outside the NUM_MSGS input and output pairs SHALL be written.
REQ-018 Messages are processed strictly in ascending index order.

Reset
REQ-019 While reset is high: state=RD_HI, index=0, done=0, no memory writes.
REQ-020 Reset SHALL NOT clear dm1.core; preloaded inputs survive reset.
REQ-021 Reset mid-operation aborts the run and restarts from message 0; partially written outputs are overwritten by the restarted run.
REQ-022 Reset asserted in DONE lowers done on the next edge and starts a new run.

Configuration
REQ-023 Macro DM_ZERO_INIT_EN: if defined, dm1.core SHALL be all zeros at simulation time 0 (before any preload); if undefined, dm1.core SHALL have no initial value and unwritten bytes read X.

Verification
REQ-024 core[1]=0x00, core[0]=0x00 -> core[31]=0x00, core[30]=0x00.
REQ-025 core[1]=0x07, core[0]=0xFF -> core[31]=0xFF, core[30]=0xFF.
REQ-026 core[1]=0x04, core[0]=0x00 -> core[31]=0x81, core[30]=0x17; core[1]=0x00, core[0]=0x01 -> core[31]=0x00, core[30]=0x0F.
REQ-027 core[1]=0xF8, core[0]=0x00 (junk upper bits) -> core[31]=0x00, core[30]=0x00.
REQ-028 15 random messages preloaded, reset pulsed for one cycle -> done rises after edge 60 and stays high; all 15 output pairs match REQ-009/REQ-010; bytes 60..255 unchanged.
REQ-029 Reset re-asserted at edge 25, then released -> done low until 60 edges after release; final outputs correct.
